// File: rtl/bidir_link_ch_pkg.sv
// Shared definitions for the time-slotted half-duplex partner link:
// slot-state encoding, slot length and payload parity helpers.
package bidir_link_ch_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SLOT_A  = 3'd1,
    GUARD_A = 3'd2,
    SLOT_B  = 3'd3,
    GUARD_B = 3'd4
  } slot_state_e;

  // Start bit + payload + parity bit.
  function automatic int slot_bits(input int width);
    return width + 2;
  endfunction

  // Bit that makes the total count of ones over payload+parity even.
  function automatic logic even_parity(input logic [31:0] payload);
    return ^payload;
  endfunction

endpackage

// File: rtl/bidir_link_ch_tick_gen.sv
// Bit-period divider: div_cnt runs 0..DIV-1 while the link is running and
// yields the end-of-bit tick and the mid-bit sample strobe.
module link_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick,
  output logic sample
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] MID  = CW'(DIV / 2 - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_cnt <= '0;
    else if (!run || div_cnt == LAST)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  assign tick   = run && (div_cnt == LAST);
  assign sample = run && (div_cnt == MID);

endmodule

// File: rtl/bidir_link_ch.sv
// One end of the shared-wire partner link: slot sequencer, framed transmit
// shift register, receive checker with error counting, and the pin driver.
module bidir_link_ch
  import bidir_link_ch_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIV    = 4,
  parameter int GUARD  = 1,
  parameter int MASTER = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             locked,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_err,
  output logic [7:0]       err_cnt,
  output logic             link_active,
  inout  wire              data_link
);

  localparam int SLOT  = slot_bits(WIDTH);
  localparam int MAXB  = (SLOT > GUARD) ? SLOT : GUARD;
  localparam int IDX_W = $clog2(MAXB);
  localparam logic [IDX_W-1:0] SLOT_LAST  = IDX_W'(SLOT - 1);
  localparam logic [IDX_W-1:0] GUARD_LAST = IDX_W'(GUARD - 1);

  slot_state_e      state, state_next;
  logic             run, tick, sample;
  logic             slot_end, guard_end;
  logic             own_now, own_next, partner_now;
  logic             sample_bit, rx_ok;
  logic [IDX_W-1:0] bit_idx;
  logic [SLOT-1:0]  tx_shift, rx_shift;

  assign run = locked && (state != IDLE);

  link_tick_gen #(.DIV(DIV)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .tick   (tick),
    .sample (sample)
  );

  assign slot_end  = tick && (bit_idx == SLOT_LAST);
  assign guard_end = tick && (bit_idx == GUARD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Losing lock overrides every slot and drops straight back to IDLE.
  always_comb begin
    state_next = state;
    if (!locked)
      state_next = IDLE;
    else begin
      case (state)
        IDLE:    state_next = SLOT_A;
        SLOT_A:  if (slot_end)  state_next = GUARD_A;
        GUARD_A: if (guard_end) state_next = SLOT_B;
        SLOT_B:  if (slot_end)  state_next = GUARD_B;
        GUARD_B: if (guard_end) state_next = SLOT_A;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    link_active = (state != IDLE);
    own_now     = 1'b0;
    own_next    = 1'b0;
    partner_now = 1'b0;
    if (MASTER != 0) begin
      own_now     = (state == SLOT_A);
      own_next    = (state_next == SLOT_A);
      partner_now = (state == SLOT_B);
    end else begin
      own_now     = (state == SLOT_B);
      own_next    = (state_next == SLOT_B);
      partner_now = (state == SLOT_A);
    end
  end

  // A released or undriven wire must never read as a valid start bit.
  always_comb begin
    sample_bit = 1'b0;
    if (data_link == 1'b1)
      sample_bit = 1'b1;
  end

  assign rx_ok = rx_shift[0] &&
                 (rx_shift[SLOT-1] == even_parity(32'(rx_shift[WIDTH:1])));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (state_next != state)
        bit_idx <= '0;
      else if (tick)
        bit_idx <= bit_idx + 1'b1;
      if (own_next && !own_now)
        tx_shift <= {even_parity(32'(tx_data)), tx_data, 1'b1};
      else if (own_now && tick)
        tx_shift <= tx_shift >> 1;
      if (partner_now && sample)
        rx_shift <= {sample_bit, rx_shift[SLOT-1:1]};
      if (partner_now && slot_end) begin
        if (rx_ok) begin
          rx_data  <= rx_shift[WIDTH:1];
          rx_valid <= 1'b1;
        end else begin
          rx_err <= 1'b1;
          if (err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

  assign data_link = own_now ? tx_shift[0] : 1'bz;

endmodule
